// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word, PC step and NOP constants for the fetch path
// Purpose: common constants and a PC alignment helper for the fetch queue.
// Ports: none (package).
package mips_pkg;

  localparam int          WORD_W    = 32;
  localparam int          ENTRY_W   = 2 * WORD_W;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch addresses are word aligned; the low two byte-offset bits are dropped.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular FIFO holding {pc, instruction} fetch entries
// Purpose: DEPTH-entry storage with read/write pointers and an occupancy count.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset of pointers and count
//   flush  - synchronous clear of pointers and count (redirect)
//   push   - write wdata at the tail (caller guarantees not full)
//   pop    - drop the head entry (caller guarantees not empty)
//   wdata  - entry to write
//   rdata  - head entry (meaningful only when count != 0)
//   count  - occupied entries
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = ENTRY_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic [CW-1:0] count
);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is never cleared; the count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch PC and prefetch queue in front of decode
// Purpose: fetches one word per cycle from a combinational ROM into a queue,
//          presents the head to decode, and restarts fetch on redirect.
// Ports:
//   Clk        - clock, rising edge
//   Reset      - synchronous active-high reset
//   RomAddr    - byte address to ROM (the current fetch PC)
//   RomData    - combinational ROM data for RomAddr
//   Redirect   - flush queue and restart fetch at RedirectPC
//   RedirectPC - new fetch byte address (word aligned internally)
//   InstrValid - head entry present
//   InstrReady - decode accepts the head this cycle
//   Instr      - head instruction word (0 when empty)
//   InstrPC    - head instruction byte address (0 when empty)
//   Count      - occupied entries
module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [WORD_W-1:0] RomAddr,
  input  logic [WORD_W-1:0] RomData,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [WORD_W-1:0] Instr,
  output logic [WORD_W-1:0] InstrPC,
  output logic [CW-1:0]     Count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD_W-1:0]  fetch_pc;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               push;
  logic               pop;

  // Fullness is judged on the start-of-cycle count, so a pop never frees
  // room for a push in the same cycle.
  assign full       = (Count == FULL_CNT);
  assign push       = !Reset && !Redirect && !full;
  assign InstrValid = (Count != '0);
  assign pop        = InstrValid && InstrReady && !Reset && !Redirect;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc <= RESET_PC;
    end else if (Redirect) begin
      fetch_pc <= align_pc(RedirectPC);
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .EW    (ENTRY_W)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .flush (Redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc, RomData}),
    .rdata (head),
    .count (Count)
  );

  assign RomAddr = fetch_pc;
  assign Instr   = InstrValid ? head[WORD_W-1:0]       : NOP_INSTR;
  assign InstrPC = InstrValid ? head[ENTRY_W-1:WORD_W] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [CW-1:0] count;

  int  n_total = 0;
  int  n_pass  = 0;
  bit  rom_mode = 1'b0;
  bit  model_live = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .RomAddr    (rom_addr),
    .RomData    (rom_data),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .InstrValid (instr_valid),
    .InstrReady (instr_ready),
    .Instr      (instr),
    .InstrPC    (instr_pc),
    .Count      (count)
  );

  // ROM: word i holds i*4 in mode 0; mode 1 scrambles so data differs from PC.
  function automatic logic [31:0] rom_fn(input logic [31:0] a, input bit mode);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mode) w = (w * 32'd2654435761) ^ 32'hC3A5_5A3C;
    return w;
  endfunction

  assign rom_data = rom_fn(rom_addr, rom_mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of fetched entries and a fetch PC.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pc = 32'h0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (redirect) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        bit do_push;
        do_push = (mq.size() < DEPTH);
        if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: m_pc, data: rom_fn(m_pc, rom_mode)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_live) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("valid", 32'(instr_valid), 32'(mq.size() != 0));
      chk("rom_addr", rom_addr, m_pc);
      chk("instr", instr, (mq.size() != 0) ? mq[0].data : 32'h0);
      chk("instr_pc", instr_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  initial begin
    // Reset release with decode always ready.
    reset = 1'b1; instr_ready = 1'b1;
    cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_romaddr", rom_addr, 32'h0);
    reset = 1'b0;
    cyc();
    chk("s1_valid", 32'(instr_valid), 32'd1);
    chk("s1_pc0", instr_pc, 32'h0);
    chk("s1_instr0", instr, 32'h0);
    cyc();
    chk("s1_pc4", instr_pc, 32'h4);
    cyc();
    chk("s1_pc8", instr_pc, 32'h8);
    chk("s1_instr8", instr, 32'h8);

    // Decode stalled from reset: queue fills.
    reset = 1'b1; instr_ready = 1'b0;
    cyc();
    reset = 1'b0;
    repeat (4) cyc();
    chk("s2_count", 32'(count), 32'd4);
    chk("s2_romaddr", rom_addr, 32'h10);
    chk("s2_headpc", instr_pc, 32'h0);
    cyc();
    chk("s2_hold_count", 32'(count), 32'd4);
    chk("s2_hold_pc", instr_pc, 32'h0);

    // Full queue, one pop: no push that cycle, push of 0x10 next.
    instr_ready = 1'b1;
    cyc();
    chk("s3_count", 32'(count), 32'd3);
    chk("s3_romaddr", rom_addr, 32'h10);
    instr_ready = 1'b0;
    cyc();
    chk("s3_count_next", 32'(count), 32'd4);
    chk("s3_romaddr_next", rom_addr, 32'h14);

    // Redirect with Count = 3.
    instr_ready = 1'b1;
    cyc();
    chk("s4_pre_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h43; instr_ready = 1'b0;
    cyc();
    chk("s4_count", 32'(count), 32'd0);
    chk("s4_romaddr", rom_addr, 32'h40);
    redirect = 1'b0;
    cyc();
    chk("s4_pc", instr_pc, 32'h40);
    chk("s4_instr", instr, 32'h40);

    // Reset wins over Redirect.
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    cyc();
    chk("s5_romaddr", rom_addr, 32'h0);
    chk("s5_count", 32'(count), 32'd0);
    reset = 1'b0; redirect = 1'b0;

    // Fetch PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    chk("s6_romaddr", rom_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    cyc();
    chk("s6_wrap", rom_addr, 32'h0);
    chk("s6_pc", instr_pc, 32'hFFFF_FFFC);
    chk("s6_instr", instr, 32'hFFFF_FFFC);

    // Randomized traffic with a scrambled ROM image.
    rom_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int ready_pct;
      ready_pct = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 60 : 95);
      instr_ready = ($urandom_range(99) < ready_pct);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      reset       = ($urandom_range(199) == 0);
      cyc();
    end
    reset = 1'b0; redirect = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 4, queue entries (power of two, 2..16)
- RESET_PC, 32'h0000_0000, first fetch byte address after reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clk, in, 1, single clock; all state updates on rising edge
- Reset, in, 1, synchronous, active-high
- RomAddr, out, 32, byte address to instruction ROM; ROM indexes RomAddr[31:2]
- RomData, in, 32, combinational ROM read data for RomAddr
- Redirect, in, 1, branch/jump taken; flush queue and restart fetch
- RedirectPC, in, 32, new fetch byte address
- InstrValid, out, 1, head entry present
- InstrReady, in, 1, decode accepts head this cycle
- Instr, out, 32, head instruction word
- InstrPC, out, 32, byte address of head instruction
- Count, out, clog2(DEPTH+1), occupied entries

Function
REQ-003 The block SHALL hold FetchPC, drive RomAddr = FetchPC combinationally, and store {FetchPC, RomData} pairs in a DEPTH-entry circular FIFO.
REQ-004 Push SHALL occur when Count < DEPTH at the start of the cycle and Redirect = 0; on push FetchPC <= FetchPC + 4, wrapping modulo 2^32.
REQ-005 A pop in the same cycle SHALL NOT enable a push when full; a full queue with a pop ends with Count = DEPTH-1.
REQ-006 Pop SHALL occur when InstrValid and InstrReady are both 1; the read pointer advances modulo DEPTH.
REQ-007 Simultaneous push and pop with 0 < Count < DEPTH SHALL leave Count unchanged.
REQ-008 InstrValid SHALL equal (Count != 0); Instr and InstrPC SHALL show the head entry when valid and 32'h0 when empty.
REQ-009 Latency: an instruction fetched in cycle N SHALL be visible at the head no earlier than cycle N+1.
REQ-010 Redirect = 1 SHALL, in one cycle: set Count = 0, reset both pointers, load FetchPC <= {RedirectPC[31:2], 2'b00}, and suppress the push.
REQ-011 A head handshake in a Redirect cycle SHALL count as consumed; no other queued entry survives.
REQ-012 Back-to-back Redirects SHALL each reload FetchPC; the last one wins.
REQ-013 With InstrReady = 0 the head entry, InstrPC and Count SHALL hold stable.
REQ-014 Pointer and count arithmetic SHALL be unsigned; pointers are clog2(DEPTH) bits wide and wrap without special-case logic.

Reset
REQ-015 On Reset = 1 at a rising edge: FetchPC = RESET_PC, both pointers = 0, Count = 0, InstrValid = 0, Instr = 0, InstrPC = 0.
REQ-016 Reset SHALL take priority over Redirect, push and pop in the same cycle.
REQ-017 Reset asserted mid-operation SHALL discard all queued entries; fetch restarts at RESET_PC the cycle after Reset deasserts.
REQ-018 FIFO storage contents need not be cleared; outputs mask them via Count.

Structure
REQ-019 Shared package mips_pkg SHALL hold WORD_W = 32, PC_STEP = 4 and NOP_INSTR = 32'h0000_0000.
REQ-020 Storage and pointers SHALL live in one sub-module fetch_fifo (parameterised by DEPTH, entry width 64); FetchPC, push/pop control and redirect logic stay in instr_fetch_queue.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with ROM word i = i*4.
- Reset release, InstrReady = 1 -> cycle 1: InstrValid = 1, InstrPC = 0x0, Instr = 0x0; then InstrPC steps 0x4, 0x8, ... one per cycle.
- InstrReady = 0 from reset -> after 4 cycles Count = 4, RomAddr = 0x10, head InstrPC = 0x0 held.
- Full queue, then InstrReady = 1 for one cycle -> Count = 3, no push that cycle; next cycle push of PC 0x10.
- Redirect = 1 with RedirectPC = 0x43 while Count = 3 -> next cycle Count = 0, RomAddr = 0x40; following cycle InstrPC = 0x40, Instr = 0x40.
- Reset and Redirect asserted together with RedirectPC = 0x80 -> FetchPC = 0x0, Count = 0.
- FetchPC = 0xFFFF_FFFC via Redirect -> next push wraps RomAddr to 0x0000_0000.
